// File: rtl/spi_slave_fifo_param.sv
// SPI slave with WIDTH-bit words, all four SPI modes, selectable bit order and TX/RX FIFOs.
// SCLK, SS and MOSI are oversampled in the i_clk domain; multi-word frames reload back-to-back.
module spi_slave_fifo_param #(
    parameter int               WIDTH     = 8,
    parameter int               TX_DEPTH  = 4,
    parameter int               RX_DEPTH  = 4,
    parameter logic [WIDTH-1:0] FILL_WORD = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sckl,
    input  logic                          i_SS,
    input  logic                          i_MOSI,
    input  logic [1:0]                    i_mode,
    input  logic                          i_MSB,
    input  logic                          i_DV,
    input  logic [WIDTH-1:0]              i_parallel_in,
    input  logic                          i_read_enable,
    input  logic                          i_clear_flags,
    output logic                          o_MISO,
    output logic                          o_miso_oe,
    output logic [WIDTH-1:0]              o_parallel_out,
    output logic                          o_done,
    output logic [WIDTH-1:0]              o_fifo_out,
    output logic                          o_fifo_valid,
    output logic                          o_rx_empty,
    output logic                          o_tx_full,
    output logic [$clog2(RX_DEPTH+1)-1:0] o_rx_count,
    output logic                          o_rx_overrun,
    output logic                          o_tx_underrun
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = $clog2(WIDTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_q, ss_q;
    logic [1:0]       mosi_q;
    logic             cpol_q, cpha_q, msb_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] tx_word_q, rx_shift_q, par_out_q;
    logic             miso_q, done_q;

    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]   tx_wr_q, tx_rd_q;
    logic [TCW-1:0]   tx_cnt_q;
    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]   rx_wr_q, rx_rd_q;
    logic [RCW-1:0]   rx_cnt_q;
    logic [WIDTH-1:0] fifo_out_q;
    logic             fifo_valid_q, rx_ovr_q, tx_und_q;

    logic ss_low, ss_fall, sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, mosi_s, word_done;
    logic tx_pop, rx_push, tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_ok, tx_pop_ok, rx_pop_ok, rx_push_ok, overrun_set, underrun_set;
    logic [WIDTH-1:0] load_word, rx_next;
    logic [IW-1:0]    tx_idx;

    // Stage 1/2 synchronise; edges compare stage 2 against stage 3.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sclk_q <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sckl};
            ss_q   <= {ss_q[1:0], i_SS};
            mosi_q <= {mosi_q[0], i_MOSI};
        end
    end

    assign ss_low      = ~ss_q[1];
    assign ss_fall     = ~ss_q[1] & ss_q[2];
    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign mosi_s      = mosi_q[1];
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign word_done   = (state_q == S_SHIFT) && ss_low && sample_edge && (bit_cnt_q == LAST_CNT);

    assign rx_next = msb_q ? {rx_shift_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift_q[WIDTH-1:1]};
    assign tx_idx  = msb_q ? IW'(LAST_CNT - bit_cnt_q) : IW'(bit_cnt_q);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ss_fall) state_d = S_LOAD;
            S_LOAD:  state_d = ss_low ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (!ss_low)        state_d = S_IDLE;
                else if (word_done) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        load_word = tx_empty ? FILL_WORD : tx_mem[tx_rd_q];
        case (state_q)
            S_LOAD:  tx_pop  = ss_low;
            S_SHIFT: rx_push = word_done;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b0;
            bit_cnt_q  <= '0;
            tx_word_q  <= '0;
            rx_shift_q <= '0;
            par_out_q  <= '0;
            miso_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= word_done;
            if (state_q == S_IDLE) begin
                miso_q <= 1'b0;
                if (ss_fall) {cpol_q, cpha_q, msb_q} <= {i_mode, i_MSB};
            end
            if (tx_pop) begin
                tx_word_q <= load_word;
                bit_cnt_q <= '0;
                if (!cpha_q) miso_q <= msb_q ? load_word[WIDTH-1] : load_word[0];
            end
            if (state_q == S_SHIFT) begin
                if (sample_edge) begin
                    rx_shift_q <= rx_next;
                    bit_cnt_q  <= word_done ? '0 : bit_cnt_q + 1'b1;
                end
                // With CPHA=0 the trailing edge after a reload belongs to the previous word.
                if (shift_edge && (cpha_q || bit_cnt_q != '0)) miso_q <= tx_word_q[tx_idx];
            end
            if (word_done) par_out_q <= rx_next;
        end
    end

    assign tx_empty     = (tx_cnt_q == '0);
    assign tx_full      = (tx_cnt_q == TCW'(TX_DEPTH));
    assign tx_push_ok   = i_DV & ~tx_full;
    assign tx_pop_ok    = tx_pop & ~tx_empty;
    assign underrun_set = tx_pop & tx_empty;

    assign rx_empty    = (rx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == RCW'(RX_DEPTH));
    assign rx_pop_ok   = i_read_enable & ~rx_empty;
    assign rx_push_ok  = rx_push & (~rx_full | rx_pop_ok);
    assign overrun_set = rx_push & rx_full & ~rx_pop_ok;

    always_ff @(posedge i_clk) begin
        if (tx_push_ok) tx_mem[tx_wr_q] <= i_parallel_in;
        if (rx_push_ok) rx_mem[rx_wr_q] <= rx_next;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_cnt_q     <= '0;
            fifo_out_q   <= '0;
            fifo_valid_q <= 1'b0;
            rx_ovr_q     <= 1'b0;
            tx_und_q     <= 1'b0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop_ok)  tx_rd_q <= tx_rd_q + 1'b1;
            case ({tx_push_ok, tx_pop_ok})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: ;
            endcase
            if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop_ok)  rx_rd_q <= rx_rd_q + 1'b1;
            case ({rx_push_ok, rx_pop_ok})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: ;
            endcase
            fifo_valid_q <= rx_pop_ok;
            if (rx_pop_ok) fifo_out_q <= rx_mem[rx_rd_q];
            // A set event in the same cycle as a clear keeps the flag set.
            if (overrun_set)        rx_ovr_q <= 1'b1;
            else if (i_clear_flags) rx_ovr_q <= 1'b0;
            if (underrun_set)       tx_und_q <= 1'b1;
            else if (i_clear_flags) tx_und_q <= 1'b0;
        end
    end

    assign o_miso_oe      = ss_low;
    assign o_MISO         = miso_q & ss_low;
    assign o_parallel_out = par_out_q;
    assign o_done         = done_q;
    assign o_fifo_out     = fifo_out_q;
    assign o_fifo_valid   = fifo_valid_q;
    assign o_rx_empty     = rx_empty;
    assign o_tx_full      = tx_full;
    assign o_rx_count     = rx_cnt_q;
    assign o_rx_overrun   = rx_ovr_q;
    assign o_tx_underrun  = tx_und_q;

endmodule
